// File: rtl/nco_iq_pkg.sv
// nco_iq_pkg: rotation encodings and the round/saturate helpers shared by
// the NCO I/Q unpacker and its per-channel lane.
package nco_iq_pkg;

    localparam logic [1:0] ROT_0   = 2'd0;
    localparam logic [1:0] ROT_90  = 2'd1;
    localparam logic [1:0] ROT_180 = 2'd2;
    localparam logic [1:0] ROT_270 = 2'd3;

    // Wide signed carrier for the helpers; callers sign-extend into it
    // and size-cast the result back down to their own width.
    typedef logic signed [31:0] wide_t;

    // Negate a w-bit value; the most negative code maps to the most
    // positive one instead of wrapping.
    function automatic wide_t sat_neg(input wide_t x, input int w);
        wide_t lo;
        lo = -(32'sd1 <<< (w - 1));
        if (x == lo) begin
            return (32'sd1 <<< (w - 1)) - 32'sd1;
        end
        return -x;
    endfunction

    // Round half up from d_w to o_w bits. Only the positive side can
    // overflow, since the rounding offset is always positive.
    function automatic wide_t round_sat(input wide_t x, input int d_w,
                                        input int o_w);
        int    r;
        wide_t hi;
        wide_t y;
        r  = d_w - o_w;
        hi = (32'sd1 <<< (o_w - 1)) - 32'sd1;
        if (r == 0) begin
            return x;
        end
        y = (x + (32'sd1 <<< (r - 1))) >>> r;
        if (y > hi) begin
            return hi;
        end
        return y;
    endfunction

endpackage

// File: rtl/nco_iq_lane.sv
// nco_iq_lane: one channel's round (stage 1) and quadrant rotate (stage 2).
// Ports: clk, rst_n; ld1/ld2 stage load strobes from the top; cos_in/sin_in
// raw D_WIDTH fields; rot_in quadrant select; cos_out/sin_out O_WIDTH result.
module nco_iq_lane
    import nco_iq_pkg::*;
#(
    parameter int D_WIDTH = 12,
    parameter int O_WIDTH = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ld1,
    input  logic               ld2,
    input  logic [D_WIDTH-1:0] cos_in,
    input  logic [D_WIDTH-1:0] sin_in,
    input  logic [1:0]         rot_in,
    output logic [O_WIDTH-1:0] cos_out,
    output logic [O_WIDTH-1:0] sin_out
);

    logic signed [O_WIDTH-1:0] c1;
    logic signed [O_WIDTH-1:0] s1;
    logic        [1:0]         rot1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c1   <= '0;
            s1   <= '0;
            rot1 <= ROT_0;
        end else if (ld1) begin
            c1   <= O_WIDTH'(round_sat(wide_t'($signed(cos_in)),
                                       D_WIDTH, O_WIDTH));
            s1   <= O_WIDTH'(round_sat(wide_t'($signed(sin_in)),
                                       D_WIDTH, O_WIDTH));
            rot1 <= rot_in;
        end
    end

    logic signed [O_WIDTH-1:0] neg_c;
    logic signed [O_WIDTH-1:0] neg_s;
    logic signed [O_WIDTH-1:0] rot_c;
    logic signed [O_WIDTH-1:0] rot_s;

    assign neg_c = O_WIDTH'(sat_neg(wide_t'(c1), O_WIDTH));
    assign neg_s = O_WIDTH'(sat_neg(wide_t'(s1), O_WIDTH));

    always_comb begin
        rot_c = c1;
        rot_s = s1;
        unique case (rot1)
            ROT_0: begin
                rot_c = c1;
                rot_s = s1;
            end
            ROT_90: begin
                rot_c = neg_s;
                rot_s = c1;
            end
            ROT_180: begin
                rot_c = neg_c;
                rot_s = neg_s;
            end
            ROT_270: begin
                rot_c = s1;
                rot_s = neg_c;
            end
        endcase
    end

    // Outputs load only with a valid word so the last carrier sample
    // stays on the bus between words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cos_out <= '0;
            sin_out <= '0;
        end else if (ld2) begin
            cos_out <= rot_c;
            sin_out <= rot_s;
        end
    end

endmodule

// File: rtl/nco_iq_unpack.sv
// nco_iq_unpack: splits an N-channel packed NCO word into rounded, rotated
// cos/sin samples through a 2-stage pipeline with valid/ready handshake.
// Ports: clk, rst_n; s_tdata/s_tvalid/s_tready input stream; rot_sel
// per-channel quadrant; m_cos/m_sin/m_tvalid/m_tready output stream;
// underrun_cnt/underrun_clr counter, built only with NCO_IQ_UNDERRUN_CNT_EN.
module nco_iq_unpack
    import nco_iq_pkg::*;
#(
    parameter int N_CH    = 2,
    parameter int FIELD_W = 16,
    parameter int D_WIDTH = 12,
    parameter int O_WIDTH = 12
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_CH*2*FIELD_W-1:0] s_tdata,
    input  logic                    s_tvalid,
    output logic                    s_tready,
    input  logic [N_CH*2-1:0]       rot_sel,
    output logic [N_CH*O_WIDTH-1:0] m_cos,
    output logic [N_CH*O_WIDTH-1:0] m_sin,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic [15:0]             underrun_cnt,
    input  logic                    underrun_clr
);

    logic en;
    logic v1;

    // One enable for the whole pipe: it moves unless the output is stuck.
    assign en       = !m_tvalid || m_tready;
    assign s_tready = en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1       <= 1'b0;
            m_tvalid <= 1'b0;
        end else if (en) begin
            v1       <= s_tvalid;
            m_tvalid <= v1;
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_lane
        nco_iq_lane #(
            .D_WIDTH(D_WIDTH),
            .O_WIDTH(O_WIDTH)
        ) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .ld1    (en && s_tvalid),
            .ld2    (en && v1),
            .cos_in (s_tdata[k*2*FIELD_W +: D_WIDTH]),
            .sin_in (s_tdata[k*2*FIELD_W+FIELD_W +: D_WIDTH]),
            .rot_in (rot_sel[k*2 +: 2]),
            .cos_out(m_cos[k*O_WIDTH +: O_WIDTH]),
            .sin_out(m_sin[k*O_WIDTH +: O_WIDTH])
        );
    end

    // Padding MSBs of each field carry no information.
    logic unused_pad;
    assign unused_pad = ^s_tdata;

`ifdef NCO_IQ_UNDERRUN_CNT_EN
    logic seen_hs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen_hs      <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            if (m_tvalid && m_tready) begin
                seen_hs <= 1'b1;
            end
            if (underrun_clr) begin
                underrun_cnt <= '0;
            end else if (seen_hs && m_tready && !m_tvalid &&
                         underrun_cnt != 16'hFFFF) begin
                underrun_cnt <= underrun_cnt + 16'd1;
            end
        end
    end
`else
    logic unused_clr;
    assign unused_clr   = underrun_clr;
    assign underrun_cnt = '0;
`endif

endmodule

// File: doc/nco_iq_unpack.md
Name: nco_iq_unpack

Overview:
- Multi-channel successor to the single-channel DDS cos/sin splitter.
- Accepts a packed AXI-stream word from an N-channel NCO/DDS and extracts per-channel signed cos/sin fields.
- Rounds and saturates each field to O_WIDTH, then applies a per-channel quadrant rotation (0/90/180/270 deg) for PSK carrier phase correction.
- Sits between the DDS IP and the mixer/Costas loop; full valid/ready handshake with backpressure.

Parameters:
- N_CH, 2, number of NCO channels packed in s_tdata.
- FIELD_W, 16, byte-padded width of one cos or sin field in s_tdata.
- D_WIDTH, 12, significant signed bits in each field (LSB-aligned); must satisfy D_WIDTH <= FIELD_W.
- O_WIDTH, 12, output sample width; must satisfy O_WIDTH <= D_WIDTH.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- s_tdata  in  N_CH*2*FIELD_W  per channel k, cos at bits [k*2*FIELD_W +: D_WIDTH] and sin at bits [k*2*FIELD_W+FIELD_W +: D_WIDTH].
- s_tvalid  in  1  input word valid.
- s_tready  out  1  input accepted when s_tvalid && s_tready.
- rot_sel  in  N_CH*2  per-channel quadrant select, sampled together with the accepted word.
- m_cos  out  N_CH*O_WIDTH  signed cos, channel k at [k*O_WIDTH +: O_WIDTH].
- m_sin  out  N_CH*O_WIDTH  signed sin, same packing as m_cos.
- m_tvalid  out  1  output valid.
- m_tready  in  1  downstream ready.
- underrun_cnt  out  16  output underrun count (see Optional Feature).
- underrun_clr  in  1  synchronous clear for underrun_cnt.

Behaviour:
- Reset (async assert, sync release): m_cos, m_sin, m_tvalid, pipeline valids, captured rot_sel and underrun_cnt all 0.
- Pipeline:
  - 2 stages, single global enable en = !m_tvalid || m_tready.
  - s_tready = en, combinational, with no combinational path from s_tvalid.
  - After reset, s_tready is 1.
- Stage 1 (on en):
  - Capture fields and rot_sel, set v1 = s_tvalid.
  - Round: R = D_WIDTH-O_WIDTH. If R > 0, add 2^(R-1), then arithmetic-shift right by R, saturating positive overflow to +(2^(O_WIDTH-1)-1). If R = 0, pass through.
- Stage 2 (on en):
  - Apply rotation per channel, where (c,s) are the rounded values:
    - 0: (c, s)
    - 1: (-s, c)
    - 2: (-c, -s)
    - 3: (s, -c)
  - Negation saturates: -(-2^(O_WIDTH-1)) yields +(2^(O_WIDTH-1)-1).
  - m_tvalid <= v1.
- Latency is 2 cycles from accepted input to m_tvalid with no backpressure. Throughput is 1 word per cycle.
- Backpressure: while m_tvalid && !m_tready, every stage and output holds its value and s_tready = 0. No data is lost or duplicated.
- Holding: when no new valid word arrives, m_cos/m_sin keep their last values and only m_tvalid deasserts. This keeps mixers fed a steady carrier.
- rot_sel changes apply only to words accepted after the change. In-flight words keep the rotation they were captured with.
- Padding bits (FIELD_W-D_WIDTH MSBs of each field) are ignored; no sign-check is performed on them.
- Reset mid-operation flushes both stages immediately; the first post-reset output needs a fresh input.

Optional Feature:
- Macro: NCO_IQ_UNDERRUN_CNT_EN.
- Defined:
  - underrun_cnt increments (saturating at 16'hFFFF) on each cycle with m_tready=1 and m_tvalid=0, counted only after the first output handshake since reset.
  - underrun_clr zeroes the count; if clear and increment coincide, clear wins.
- Undefined: underrun_cnt is tied to 0, underrun_clr is ignored, and no counter logic is synthesised.

Decomposition:
- Package nco_iq_pkg holds:
  - rotation encodings ROT_0/ROT_90/ROT_180/ROT_270 (2'd0..3).
  - function sat_neg(x, w).
  - function round_sat(x, d_w, o_w).
- Sub-module nco_iq_lane: one channel's round, rotate and saturate datapath, excluding handshake. It is instantiated N_CH times under a generate loop; the top owns all valid/ready control.

Test Plan:
- N_CH=2, O_WIDTH=D_WIDTH=12: input ch0 cos=0x7FF sin=0x000, ch1 cos=0x800 sin=0x400, rot_sel=0, m_tready=1 -> 2 cycles later m_tvalid=1, ch0=(2047,0), ch1=(-2048,1024).
- rot_sel ch0=2 with ch0 cos=0x800 -> m_cos ch0=+2047 (saturated negation). rot_sel ch0=1 with (c=100,s=-50) -> (50,100).
- O_WIDTH=10, D_WIDTH=12, cos=0x7FF -> rounding overflow saturates to 511. cos=0x006 (6) -> 2. cos=0xFFA (-6) -> -1.
- Stream 8 words with m_tready low for cycles 3-5 -> s_tready low in the same cycles, all 8 words emerge in order with no drops or duplicates, outputs stable while stalled.
- Assert rst_n=0 mid-stream with 2 words in flight -> m_tvalid=0 and outputs 0 immediately. After release, no stale word appears.
- Macro defined: after one handshake, hold s_tvalid=0 and m_tready=1 for 5 cycles -> underrun_cnt=5. Pulse underrun_clr -> 0. Macro undefined -> underrun_cnt stays 0.
